hit_stamp_fifo: RTL and testbench

- Next stage directly downstream of the asynchronous per-channel edge-capture register in the TrigTDC input path.
- Samples the capture register's WIDTH-bit hit vector on the system clock and detects new hits (sampled rising edges).
- Stamps each hit with a free-running coarse time, serialises simultaneous hits lowest-channel-first into a first-word-fall-through FIFO, and presents them on a valid/ready readout port. Hit losses are counted.

---
 rtl/hit_stamp_fifo.sv | 152 +++++++++++++++
 tb/tb_hit_stamp_fifo.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_stamp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hit_stamp_fifo                                                             |
// | Hit edge detection, coarse time stamping and lowest-channel-first FWFT     |
// | queueing of TrigTDC hits, with sticky overflow and drop counting.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module hit_stamp_fifo #(
    parameter int WIDTH   = 46,
    parameter int CH_BITS = 6,
    parameter int TS_BITS = 16,
    parameter int AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   hit_in,
    input  logic               enable,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_BITS-1:0] out_chan,
    output logic [TS_BITS-1:0] out_ts,
    output logic [AW:0]        fifo_count,
    output logic               overflow,
    output logic [15:0]        drop_cnt,
    input  logic               clr_status
);

    localparam int                 c_DEPTH   = 1 << AW;
    localparam logic [AW:0]        c_FULL    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]        c_CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]      c_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   c_BIT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TS_BITS-1:0] c_TS_ONE  = {{(TS_BITS-1){1'b0}}, 1'b1};

    logic [TS_BITS-1:0] r_ts;
    logic [TS_BITS-1:0] r_ts_a;
    logic [TS_BITS-1:0] r_ts_s;
    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_s2;
    logic [WIDTH-1:0]   r_active;
    logic [WIDTH-1:0]   r_staged;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;
    logic [CH_BITS-1:0] r_mem_chan [c_DEPTH];
    logic [TS_BITS-1:0] r_mem_ts   [c_DEPTH];

    logic [WIDTH-1:0]   w_new;
    logic [WIDTH-1:0]   w_act_rem;
    logic [CH_BITS-1:0] w_low_idx;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;

    assign w_new     = r_s1 & ~r_s2 & {WIDTH{enable}};
    assign w_full    = (r_count == c_FULL);
    assign w_push    = (|r_active) && !w_full;
    assign w_pop     = out_valid && out_ready;
    // x & (x-1) clears the lowest set bit, i.e. the channel being written now.
    assign w_act_rem = w_push ? (r_active & (r_active - c_BIT_ONE)) : r_active;
    assign w_drop    = (|w_act_rem) && (|r_staged) && (|w_new);

    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_active[i]) begin
                w_low_idx = CH_BITS'(i);
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_chan   = out_valid ? r_mem_chan[r_rd_ptr] : '0;
    assign out_ts     = out_valid ? r_mem_ts[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_ts_a     <= '0;
            r_ts_s     <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_active   <= '0;
            r_staged   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= r_ts + c_TS_ONE;
            r_s1 <= hit_in;
            r_s2 <= r_s1;

            if (w_act_rem == '0) begin
                if (r_staged != '0) begin
                    r_active <= r_staged;
                    r_ts_a   <= r_ts_s;
                    r_staged <= w_new;
                    r_ts_s   <= r_ts;
                end else begin
                    r_active <= w_new;
                    r_ts_a   <= r_ts;
                end
            end else begin
                r_active <= w_act_rem;
                if (r_staged == '0) begin
                    r_staged <= w_new;
                    r_ts_s   <= r_ts;
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end

            // A drop in the clearing cycle survives the clear as the first count.
            if (clr_status) begin
                r_overflow <= w_drop;
                r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_chan[r_wr_ptr] <= w_low_idx;
            r_mem_ts[r_wr_ptr]   <= r_ts_a;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hit_stamp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hit_stamp_fifo                                                          |
// | Self-checking bench for hit_stamp_fifo against a queue-based hit model.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_hit_stamp_fifo;

    localparam int WIDTH   = 46;
    localparam int CH_BITS = 6;
    localparam int TS_BITS = 16;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;

    logic               clk        = 1'b0;
    logic               rst        = 1'b1;
    logic [WIDTH-1:0]   hit_in     = '0;
    logic               enable     = 1'b0;
    logic               out_ready  = 1'b0;
    logic               clr_status = 1'b0;
    logic               out_valid;
    logic [CH_BITS-1:0] out_chan;
    logic [TS_BITS-1:0] out_ts;
    logic [AW:0]        fifo_count;
    logic               overflow;
    logic [15:0]        drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hit_stamp_fifo #(
        .WIDTH  (WIDTH),
        .CH_BITS(CH_BITS),
        .TS_BITS(TS_BITS),
        .AW     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hit_in    (hit_in),
        .enable    (enable),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_ts    (out_ts),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending hit batches (at most two) feeding a
    // queue of readout entries (at most DEPTH).
    typedef struct {
        logic [CH_BITS-1:0] ch;
        logic [TS_BITS-1:0] ts;
    } ent_t;
    typedef struct {
        logic [WIDTH-1:0]   mask;
        logic [TS_BITS-1:0] ts;
    } batch_t;

    ent_t               mq[$];
    batch_t             bq[$];
    logic [WIDTH-1:0]   m_s1;
    logic [WIDTH-1:0]   m_s2;
    logic [TS_BITS-1:0] m_ts;
    logic               m_ovf;
    logic [15:0]        m_drop;

    logic [44:0] dut_vec;
    assign dut_vec = {out_valid, out_chan, out_ts, fifo_count, overflow, drop_cnt};

    function automatic void model_reset();
        mq.delete();
        bq.delete();
        m_s1   = '0;
        m_s2   = '0;
        m_ts   = '0;
        m_ovf  = 1'b0;
        m_drop = '0;
    endfunction

    function automatic void model_step();
        logic [WIDTH-1:0] nw;
        logic             room;
        logic             dropped;
        logic             found;
        batch_t           b;
        ent_t             e;
        nw   = enable ? (m_s1 & ~m_s2) : '0;
        room = (mq.size() < DEPTH);
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (bq.size() != 0 && room) begin
            b     = bq.pop_front();
            found = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (!found && b.mask[i]) begin
                    e.ch      = CH_BITS'(i);
                    e.ts      = b.ts;
                    b.mask[i] = 1'b0;
                    found     = 1'b1;
                    mq.push_back(e);
                end
            end
            if (b.mask != '0) bq.push_front(b);
        end
        dropped = (nw != '0) && (bq.size() == 2);
        if (nw != '0 && !dropped) begin
            b.mask = nw;
            b.ts   = m_ts;
            bq.push_back(b);
        end
        if (clr_status) begin
            m_ovf  = dropped;
            m_drop = dropped ? 16'd1 : 16'd0;
        end else if (dropped) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        m_s2 = m_s1;
        m_s1 = hit_in;
        m_ts = m_ts + 16'd1;
    endfunction

    function automatic logic [44:0] model_vec();
        logic v;
        v = (mq.size() != 0);
        return {v, v ? mq[0].ch : 6'd0, v ? mq[0].ts : 16'd0, 5'(mq.size()), m_ovf, m_drop};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        hit_in     = '0;
        clr_status = 1'b0;
        out_ready  = 1'b0;
        enable     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected all zero", dut_vec);
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        out_ready = 1'b1;
        repeat (4) tick();
        hit_in[3] = 1'b1;
        tick();
        tick();
        hit_in = '0;
        tick();
        n_checks++;
        if ({out_valid, out_chan, out_ts} !== {1'b1, 6'd3, 16'd5}) begin
            n_fail++;
            $display("FAIL single_head: got v=%0b ch=%0d ts=%0d, expected v=1 ch=3 ts=5",
                     out_valid, out_chan, out_ts);
        end
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL single_model: got %h, expected %h", dut_vec, model_vec());
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got out_valid=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [CH_BITS-1:0] ch[3];
        logic [TS_BITS-1:0] ts[3];
        int n;
        int mm;
        n  = 0;
        mm = 0;
        out_ready  = 1'b1;
        hit_in     = '0;
        hit_in[40] = 1'b1;
        hit_in[0]  = 1'b1;
        hit_in[17] = 1'b1;
        tick();
        hit_in = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dut_vec !== model_vec()) mm++;
            if (out_valid) begin
                if (n < 3) begin
                    ch[n] = out_chan;
                    ts[n] = out_ts;
                end
                n++;
            end
        end
        n_checks++;
        if (mm != 0) begin
            n_fail++;
            $display("FAIL simul_model: got %0d cycles differing from model, expected 0", mm);
        end
        n_checks++;
        if (n != 3 || ch[0] !== 6'd0 || ch[1] !== 6'd17 || ch[2] !== 6'd40) begin
            n_fail++;
            $display("FAIL simul_order: got n=%0d ch=%0d,%0d,%0d, expected n=3 ch=0,17,40",
                     n, ch[0], ch[1], ch[2]);
        end
        n_checks++;
        if (ts[0] !== ts[1] || ts[1] !== ts[2]) begin
            n_fail++;
            $display("FAIL simul_ts: got %0d,%0d,%0d, expected all equal", ts[0], ts[1], ts[2]);
        end
    endtask

    task automatic test_back_pressure();
        logic [TS_BITS-1:0] ts[20];
        int n;
        int bad_ch;
        int bad_ts;
        n      = 0;
        bad_ch = 0;
        bad_ts = 0;
        do_reset();
        for (int h = 0; h < 20; h++) begin
            hit_in[5] = 1'b1;
            tick();
            hit_in[5] = 1'b0;
            repeat (3) tick();
        end
        repeat (4) tick();
        n_checks++;
        if ({fifo_count, overflow, drop_cnt} !== {5'd16, 1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL bp_full: got count=%0d ovf=%0b drops=%0d, expected 16 1 2",
                     fifo_count, overflow, drop_cnt);
        end
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL bp_model: got %h, expected %h", dut_vec, model_vec());
        end
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                if (n < 20) ts[n] = out_ts;
                if (out_chan !== 6'd5) bad_ch++;
                n++;
            end
            tick();
        end
        for (int i = 0; i < 18 && i < n; i++) begin
            if (ts[i] !== 16'(1 + 4 * i)) bad_ts++;
        end
        n_checks++;
        if (n != 18 || bad_ch != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d entries (%0d wrong channel), expected 18 on ch 5",
                     n, bad_ch);
        end
        n_checks++;
        if (bad_ts != 0) begin
            n_fail++;
            $display("FAIL bp_ts: got %0d entries with wrong stamp, expected 0 (first=%0d)",
                     bad_ts, ts[0]);
        end
    endtask

    task automatic test_drop_clear();
        do_reset();
        for (int h = 0; h < 18; h++) begin
            hit_in[7] = 1'b1;
            tick();
            hit_in[7] = 1'b0;
            tick();
        end
        repeat (3) tick();
        n_checks++;
        if ({fifo_count, overflow, drop_cnt} !== {5'd16, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL dc_prefill: got count=%0d ovf=%0b drops=%0d, expected 16 0 0",
                     fifo_count, overflow, drop_cnt);
        end
        hit_in[7] = 1'b1;
        tick();
        hit_in[7] = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({overflow, drop_cnt} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL dc_drop: got ovf=%0b drops=%0d, expected 1 1", overflow, drop_cnt);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_checks++;
        if ({overflow, drop_cnt} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL dc_clear: got ovf=%0b drops=%0d, expected 0 0", overflow, drop_cnt);
        end
        hit_in[7] = 1'b1;
        tick();
        hit_in[7]  = 1'b0;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        n_checks++;
        if ({overflow, drop_cnt} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL dc_clear_drop: got ovf=%0b drops=%0d, expected 1 1",
                     overflow, drop_cnt);
        end
        out_ready = 1'b1;
        repeat (25) tick();
        n_checks++;
        if (dut_vec !== model_vec() || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dc_drained: got %h, expected %h with empty fifo", dut_vec, model_vec());
        end
    endtask

    task automatic test_enable_wrap();
        int bad;
        bad       = 0;
        out_ready = 1'b1;
        enable    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            hit_in = WIDTH'({$urandom(), $urandom()});
            tick();
            if (out_valid !== 1'b0 || fifo_count !== 5'd0 || drop_cnt !== 16'd1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_off: got %0d cycles with entries or new drops, expected 0", bad);
        end
        hit_in = '0;
        repeat (2) tick();
        enable = 1'b1;
        for (int c = 0; c < 70000 && m_ts != 16'hFFFE; c++) tick();
        n_checks++;
        if (m_ts !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wrap_reach: got ts=%h, expected FFFE within cycle budget", m_ts);
        end
        hit_in[9] = 1'b1;
        tick();
        hit_in[9] = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({out_valid, out_chan, out_ts} !== {1'b1, 6'd9, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL wrap_ts: got v=%0b ch=%0d ts=%h, expected v=1 ch=9 ts=FFFF",
                     out_valid, out_chan, out_ts);
        end
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL wrap_model: got %h, expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_async_reset();
        int stale;
        stale = 0;
        do_reset();
        hit_in = 46'hFF;
        tick();
        hit_in = '0;
        for (int c = 0; c < 20 && mq.size() != 6; c++) tick();
        n_checks++;
        if (fifo_count !== 5'd6 || bq.size() == 0) begin
            n_fail++;
            $display("FAIL ar_setup: got count=%0d pending=%0d, expected 6 and pending",
                     fifo_count, bq.size());
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, fifo_count, out_chan, out_ts} !== 28'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: got v=%0b count=%0d, expected 0 0",
                     out_valid, fifo_count);
        end
        model_reset();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid !== 1'b0 || dut_vec !== model_vec()) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL ar_stale: got %0d cycles with entries, expected 0", stale);
        end
    endtask

    task automatic test_random();
        int mm;
        int idx;
        mm = 0;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            hit_in = hit_in & WIDTH'({$urandom(), $urandom()}) & WIDTH'({$urandom(), $urandom()});
            if ($urandom_range(0, 2) == 0) begin
                idx         = int'($urandom_range(0, WIDTH - 1));
                hit_in[idx] = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) hit_in = hit_in | WIDTH'({$urandom(), $urandom()});
            out_ready  = ($urandom_range(0, 99) < (c < 600 ? 75 : 20));
            enable     = ($urandom_range(0, 15) != 0);
            clr_status = ($urandom_range(0, 40) == 0);
            tick();
            if (dut_vec !== model_vec()) begin
                mm++;
                if (mm <= 5) $display("FAIL random_cycle %0d: got %h, expected %h",
                                      c, dut_vec, model_vec());
            end
        end
        clr_status = 1'b0;
        n_checks++;
        if (mm != 0) begin
            n_fail++;
            $display("FAIL random_model: got %0d differing cycles, expected 0", mm);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_back_pressure();
        test_drop_clear();
        test_enable_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
